// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package mem_resp_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_t;

   localparam int WORD_BYTES = 4;
   localparam int BYTE_OFF_W = 2;

   localparam logic [BYTE_OFF_W-1:0] BYTE_MASK = BYTE_OFF_W'(WORD_BYTES - 1);

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous write port, combinational read port.
// Contents are deliberately never reset.
module dmem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH_WORDS = 256,
   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rd
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rd = mem[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Responder side of the CPU data-memory interface: captures a request, inserts
// WAIT_CYCLES wait states, then completes it with a one-cycle ready (and err) pulse.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int WIDX_W = ADDR_W - BYTE_OFF_W;

   mem_resp_state_t   state_q;
   logic [CNT_W-1:0]  waitCnt_q;
   logic [IDX_W-1:0]  reqIdx_q;
   logic [DATA_W-1:0] reqWdata_q;
   logic              reqRead_q;
   logic              reqWrite_q;
   logic              reqErr_q;
   logic [DATA_W-1:0] rdata_q;
   logic              ready_q;
   logic              busy_q;
   logic              err_q;

   logic              inReq;
   logic              inErr;
   logic              enterResp;
   logic [IDX_W-1:0]  accIdx;
   logic [DATA_W-1:0] accWdata;
   logic              accRead;
   logic              accWrite;
   logic              accErr;
   logic              arrayWe;
   logic [DATA_W-1:0] arrayRd;

   assign inReq = memread | memwrite;
   assign inErr = (memread & memwrite)
                | ((addr[BYTE_OFF_W-1:0] & BYTE_MASK) != '0)
                | (addr[ADDR_W-1:BYTE_OFF_W] >= WIDX_W'(DEPTH_WORDS));

   // With zero wait states the access completes on the sampling edge itself,
   // so it must be taken straight from the inputs rather than the request registers.
   always_comb begin
      enterResp = 1'b0;
      accIdx    = reqIdx_q;
      accWdata  = reqWdata_q;
      accRead   = reqRead_q;
      accWrite  = reqWrite_q;
      accErr    = reqErr_q;
      if (state_q == IDLE && inReq && WAIT_CYCLES == 0) begin
         enterResp = 1'b1;
         accIdx    = addr[BYTE_OFF_W +: IDX_W];
         accWdata  = wdata;
         accRead   = memread;
         accWrite  = memwrite;
         accErr    = inErr;
      end else if (state_q == WAIT && waitCnt_q == '0) begin
         enterResp = 1'b1;
      end
   end

   assign arrayWe = enterResp & accWrite & ~accErr & ~rst;

   dmem_array #(
      .DATA_W(DATA_W),
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk(clk),
      .we(arrayWe),
      .widx(accIdx),
      .wdata(accWdata),
      .ridx(accIdx),
      .rd(arrayRd)
   );

   // Handshake FSM; ready/err/busy are registered so they line up with the RESP state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         waitCnt_q  <= '0;
         reqIdx_q   <= '0;
         reqWdata_q <= '0;
         reqRead_q  <= 1'b0;
         reqWrite_q <= 1'b0;
         reqErr_q   <= 1'b0;
         rdata_q    <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         ready_q <= enterResp;
         err_q   <= enterResp & accErr;
         if (enterResp & accRead & ~accErr) begin
            rdata_q <= arrayRd;
         end
         case (state_q)
            IDLE: begin
               if (inReq) begin
                  reqIdx_q   <= addr[BYTE_OFF_W +: IDX_W];
                  reqWdata_q <= wdata;
                  reqRead_q  <= memread;
                  reqWrite_q <= memwrite;
                  reqErr_q   <= inErr;
                  busy_q     <= 1'b1;
                  if (WAIT_CYCLES > 0) begin
                     state_q   <= WAIT;
                     waitCnt_q <= CNT_W'(WAIT_CYCLES - 1);
                  end else begin
                     state_q <= RESP;
                  end
               end
            end
            WAIT: begin
               if (waitCnt_q == '0) begin
                  state_q <= RESP;
               end else begin
                  waitCnt_q <= waitCnt_q - 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rdata = rdata_q;
   assign ready = ready_q;
   assign busy  = busy_q;
   assign err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance (A) and a
// zero-wait instance (B) share the request inputs; each section checks one of them.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        memread;
   logic        memwrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdataA, rdataB;
   logic        readyA, busyA, errA;
   logic        readyB, busyB, errB;

   int checkCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   data_mem_responder #(
      .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(2)
   ) dutA (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
      .addr(addr), .wdata(wdata), .rdata(rdataA), .ready(readyA),
      .busy(busyA), .err(errA)
   );

   data_mem_responder #(
      .DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)
   ) dutB (
      .clk(clk), .rst(rst), .memread(memread), .memwrite(memwrite),
      .addr(addr), .wdata(wdata), .rdata(rdataB), .ready(readyB),
      .busy(busyB), .err(errB)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Holds a request until the selected instance pulses ready; lat=0 means it never did.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a,
                                input logic [31:0] d, input bit useB, output int lat,
                                output logic gotErr, output logic [31:0] gotRdata);
      @(negedge clk);
      memread  = rd;
      memwrite = wr;
      addr     = a;
      wdata    = d;
      lat      = 0;
      gotErr   = 1'b0;
      gotRdata = '0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk);
         #1;
         if (useB ? readyB : readyA) begin
            lat      = n;
            gotErr   = useB ? errB : errA;
            gotRdata = useB ? rdataB : rdataA;
            break;
         end
      end
      @(negedge clk);
      memread  = 1'b0;
      memwrite = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      int          lat;
      logic        e;
      logic [31:0] r;
      logic        sawReady;
      logic [7:0]  readyPattern;

      rst      = 1'b1;
      memread  = 1'b0;
      memwrite = 1'b0;
      addr     = '0;
      wdata    = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset rdataA", rdataA, 32'h0);
      checkOutput("reset readyA", {31'b0, readyA}, 32'h0);
      checkOutput("reset busyA", {31'b0, busyA}, 32'h0);
      checkOutput("reset errA", {31'b0, errA}, 32'h0);
      checkOutput("reset rdataB", rdataB, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Basic write then read-back with two wait states
      applyStimulus(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, e, r);
      checkOutput("wr10 latency", lat, 32'd3);
      checkOutput("wr10 err", {31'b0, e}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, e, r);
      checkOutput("rd10 latency", lat, 32'd3);
      checkOutput("rd10 err", {31'b0, e}, 32'h0);
      checkOutput("rd10 rdata", r, 32'hDEADBEEF);

      // Misaligned accesses are rejected and leave storage and rdata untouched
      applyStimulus(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, lat, e, r);
      checkOutput("rd13 latency", lat, 32'd3);
      checkOutput("rd13 err", {31'b0, e}, 32'h1);
      checkOutput("rd13 rdata", r, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b1, 32'h12, 32'h11111111, 1'b0, lat, e, r);
      checkOutput("wr12 err", {31'b0, e}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, e, r);
      checkOutput("rd10 after wr12", r, 32'hDEADBEEF);

      // Simultaneous read and write is rejected
      applyStimulus(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, lat, e, r);
      applyStimulus(1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 1'b0, lat, e, r);
      checkOutput("rdwr20 err", {31'b0, e}, 32'h1);
      applyStimulus(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, e, r);
      checkOutput("rd20 err", {31'b0, e}, 32'h0);
      checkOutput("rd20 rdata", r, 32'hA5A5A5A5);

      // Word index past the end of storage
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 1'b0, lat, e, r);
      checkOutput("rd400 err", {31'b0, e}, 32'h1);
      checkOutput("rd400 rdata", r, 32'hA5A5A5A5);

      // Reset during WAIT discards the pending write
      applyStimulus(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 1'b0, lat, e, r);
      @(negedge clk);
      memwrite = 1'b1;
      addr     = 32'h40;
      wdata    = 32'h00001234;
      @(posedge clk);
      #1;
      checkOutput("wr40 busy", {31'b0, busyA}, 32'h1);
      checkOutput("wr40 ready early", {31'b0, readyA}, 32'h0);
      @(negedge clk);
      rst      = 1'b1;
      memwrite = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst busy", {31'b0, busyA}, 32'h0);
      checkOutput("rst rdata", rdataA, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      sawReady = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         sawReady = sawReady | readyA;
      end
      checkOutput("rst no ready", {31'b0, sawReady}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, lat, e, r);
      checkOutput("rd40 rdata", r, 32'h0BADF00D);

      // Held read is serviced repeatedly, one access every four cycles
      applyStimulus(1'b0, 1'b1, 32'h8, 32'h13579BDF, 1'b0, lat, e, r);
      @(negedge clk);
      memread = 1'b1;
      addr    = 32'h8;
      readyPattern = '0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk);
         #1;
         readyPattern[i-1] = readyA;
         if (i == 3) checkOutput("held rd8 rdata", rdataA, 32'h13579BDF);
      end
      @(negedge clk);
      memread = 1'b0;
      checkOutput("held ready pattern", {24'b0, readyPattern}, 32'h44);
      repeat (4) @(posedge clk);

      // Zero-wait instance: last word and first out-of-range word
      applyStimulus(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, 1'b1, lat, e, r);
      checkOutput("B wr3FC latency", lat, 32'd1);
      checkOutput("B wr3FC err", {31'b0, e}, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h3FC, 32'h0, 1'b1, lat, e, r);
      checkOutput("B rd3FC latency", lat, 32'd1);
      checkOutput("B rd3FC rdata", r, 32'hCAFEF00D);
      applyStimulus(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, lat, e, r);
      checkOutput("B rd400 latency", lat, 32'd1);
      checkOutput("B rd400 err", {31'b0, e}, 32'h1);
      checkOutput("B rd400 rdata", r, 32'hCAFEF00D);

      repeat (4) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
